// File: rtl/rr_mux_arbiter_if.sv
// ---------------------------------------------------------------------------
// rr_mux_arbiter_if
// Bundles the request/data/grant signals shared between the four requesters
// and the round-robin mux arbiter.
//
//   req   [3:0]       per-requester request (requester side drives)
//   din   [4*DW-1:0]  packed requester data, slot i at din[i*DW +: DW]
//   gnt   [3:0]       one-hot grant (arbiter drives)
//   sel   [1:0]       binary index of the granted requester
//   dout  [DW-1:0]    forwarded data of the granted requester
//   valid             dout carries a transfer this cycle
//   busy              arbiter is in a grant tenure
//
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface rr_mux_arbiter_if #(
  parameter int DW = 8
);
  logic [3:0]      req;
  logic [4*DW-1:0] din;
  logic [3:0]      gnt;
  logic [1:0]      sel;
  logic [DW-1:0]   dout;
  logic            valid;
  logic            busy;

  modport master (
    output req,
    output din,
    input  gnt,
    input  sel,
    input  dout,
    input  valid,
    input  busy
  );

  modport slave (
    input  req,
    input  din,
    output gnt,
    output sel,
    output dout,
    output valid,
    output busy
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// rr_mux_arbiter
// Round-robin arbiter that shares a 4:1 data mux between four requesters.
// One requester holds the grant at a time for at most MAX_BURST transfers;
// on release the next requester (searching from last+1, wrapping) is loaded
// in the same edge, so back-to-back tenures have no idle cycle.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    rr_mux_arbiter_if.slave (req, din in; gnt, sel, dout, valid,
//          busy out)
//
// Parameters:
//   DW         data width per requester
//   MAX_BURST  maximum transfers per grant (>= 1)
//
// Optional build macro RR_MUX_OUT_REG_EN: when defined, dout and valid are
// registered (one cycle behind gnt/sel); arbitration timing is unchanged.
// ---------------------------------------------------------------------------
module rr_mux_arbiter #(
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  rr_mux_arbiter_if.slave   bus
);

  localparam int CW = $clog2(MAX_BURST) + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      gnt_q, gnt_d;
  logic [1:0]      sel_q, sel_d;
  logic [1:0]      last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [DW-1:0]   slot [4];
  logic            any_req;
  logic [1:0]      win_idx;
  logic            cur_valid;
  logic [DW-1:0]   cur_dout;
  logic            release_now;

  // Unpack the requester data lanes.
  for (genvar gi = 0; gi < 4; gi++) begin : g_slot
    assign slot[gi] = bus.din[gi*DW +: DW];
  end

  assign any_req = |bus.req;

  // Round-robin search: candidates last+1 .. last+4 (the last one being the
  // previous holder). Scanning from the far end and overwriting leaves the
  // closest requesting candidate as the winner.
  always_comb begin
    logic [1:0] cand;
    cand    = 2'd0;
    win_idx = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      cand = last_q + 2'(k);
      if (bus.req[cand]) begin
        win_idx = cand;
      end
    end
  end

  assign cur_valid   = (state_q == GRANT) && bus.req[sel_q];
  assign cur_dout    = cur_valid ? slot[sel_q] : '0;
  assign release_now = !bus.req[sel_q] ||
                       (cur_valid && (cnt_q == CW'(MAX_BURST - 1)));

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << win_idx;
          sel_d   = win_idx;
          last_d  = win_idx;
          cnt_d   = '0;
        end
      end

      GRANT: begin
        if (release_now) begin
          if (any_req) begin
            // Hand over directly to the next winner without passing IDLE.
            gnt_d  = 4'b0001 << win_idx;
            sel_d  = win_idx;
            last_d = win_idx;
            cnt_d  = '0;
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            cnt_d   = '0;
          end
        end else begin
          // Not releasing implies req[sel] is high, so a transfer happened.
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      last_q  <= 2'd3;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.sel  = sel_q;
  assign bus.busy = (state_q == GRANT);

`ifdef RR_MUX_OUT_REG_EN
  logic            valid_q;
  logic [DW-1:0]   dout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      dout_q  <= '0;
    end else begin
      valid_q <= cur_valid;
      dout_q  <= cur_dout;
    end
  end

  assign bus.valid = valid_q;
  assign bus.dout  = dout_q;
`else
  assign bus.valid = cur_valid;
  assign bus.dout  = cur_dout;
`endif

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter and sequencer that shares a 4:1 data mux between four requesters.
- Grants one requester at a time and drives the mux select.
- Forwards the granted requester's data with a valid strobe.
- Limits each tenure to a bounded burst so all four requesters are served fairly.

Parameters:
- DW, 8, data width per requester.
- MAX_BURST, 4, maximum transfer cycles per grant (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  per-requester request; held high while the requester has data.
- din  input  4*DW  packed requester data; requester i occupies din[i*DW +: DW].
- gnt  output  4  one-hot grant, registered.
- sel  output  2  mux select (binary index of the granted requester), registered.
- dout  output  DW  forwarded data of the granted requester.
- valid  output  1  dout carries a transfer this cycle.
- busy  output  1  high while in state GRANT.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values (while rst_n low, applied immediately):
  - gnt=0000, sel=00, valid=0, dout=0, busy=0.
  - State=IDLE, burst counter=0.
  - Internal last-grant pointer=3, so requester 0 has top priority after reset.
- Arbitration:
  - Search starts at (last+1) mod 4 and wraps.
  - The first requester with req high wins.
  - The previous holder wins only if no other requester is asking.
- State IDLE:
  - gnt=0, valid=0, dout=0, busy=0.
  - sel holds its last value.
  - If any req bit is high at a clk edge: load gnt, sel and last with the winner, clear the counter, go to GRANT.
  - Latency: req sampled high at edge N gives gnt visible after edge N.
- State GRANT (busy=1):
  - valid = req[sel] (combinational).
  - dout = din[sel] when valid, else 0.
  - The counter increments on each edge where valid=1.
- Release condition, evaluated at each edge:
  - (a) req[sel]=0, or
  - (b) valid=1 and counter == MAX_BURST-1, i.e. the MAX_BURST-th transfer completes.
- On release:
  - Arbitration runs in the same edge.
  - If any req is high, the new winner is loaded directly: zero idle cycles between tenures, counter cleared, stay in GRANT.
  - Otherwise go to IDLE with gnt=0.
- Boundary rules:
  - A requester dropping req mid-burst forfeits the remaining burst.
  - Back-to-back re-grant to the same requester is allowed only when it is the sole requester.
  - Counter width is clog2(MAX_BURST)+1. It never exceeds MAX_BURST-1.
  - MAX_BURST=1 gives a single transfer per grant.
  - gnt is always zero or one-hot. sel always equals the index of the set gnt bit while busy.
  - Reset asserted mid-burst aborts the tenure immediately: outputs go to reset values and the pointer returns to 3.

Optional Feature:
- Macro: RR_MUX_OUT_REG_EN.
- Defined:
  - dout and valid are registered: one extra cycle of latency relative to gnt/sel.
  - Both reset to 0 asynchronously.
  - Arbitration timing is unchanged.
- Undefined: dout and valid are combinational from sel/req/din, as described above.

Test Plan:
- Reset: hold rst_n=0 with req=1111 -> gnt=0000, sel=00, valid=0, dout=00, busy=0. Release -> first grant gnt=0001, sel=00.
- Single requester: req=0100 for 2 cycles, din slot 2=8'hA5 -> gnt=0100 and sel=10 one edge later. valid=1 with dout=A5 for 2 cycles. Then req drops -> IDLE, gnt=0000, busy=0.
- Full contention: req=1111 held, distinct din per slot -> grant order 0,1,2,3,0. Each tenure has exactly 4 valid cycles. No cycle with gnt=0 between tenures.
- Partial contention and fairness: req=1010 held -> grants alternate 1,3,1,3 with 4 transfers each. Requester 3 drops mid-burst after 2 transfers -> immediate switch to 1 at that edge.
- Async reset mid-burst: rst_n pulsed low for 3 ns (not aligned to clk) during a grant to 2 -> gnt=0000 immediately. After release with req=0110 -> grant goes to 1.
- RR_MUX_OUT_REG_EN defined, single requester 0 with din=8'h3C for 3 cycles -> valid/dout=3C appear one cycle after gnt=0001, last exactly 3 cycles, gnt timing identical to the undefined build.
